// File: rtl/mult_request_driver_if.sv
// Handshake bundle between the multiplier request driver and its environment.
// It carries the host command port, the operand/strobe/ack handshake to the shift-add
// multiplier, and the host result port.
//   master : the driver side (drives oCmd_Ready, oData_A/B, oValid_Data, oAck,
//            oResult_Valid, oResult, oError, oOp_Count)
//   slave  : the host plus multiplier side (drives iCmd_Valid, iCmd_A/B, iDone,
//            iProduct, iResult_Ready)
interface mult_request_driver_if #(
  parameter int WIDTH = 32
);
  logic                 iCmd_Valid;
  logic                 oCmd_Ready;
  logic [WIDTH-1:0]     iCmd_A;
  logic [WIDTH-1:0]     iCmd_B;
  logic [WIDTH-1:0]     oData_A;
  logic [WIDTH-1:0]     oData_B;
  logic                 oValid_Data;
  logic                 iDone;
  logic [2*WIDTH-1:0]   iProduct;
  logic                 oAck;
  logic                 oResult_Valid;
  logic                 iResult_Ready;
  logic [2*WIDTH-1:0]   oResult;
  logic                 oError;
  logic [15:0]          oOp_Count;

  modport master (
    input  iCmd_Valid, iCmd_A, iCmd_B, iDone, iProduct, iResult_Ready,
    output oCmd_Ready, oData_A, oData_B, oValid_Data, oAck,
           oResult_Valid, oResult, oError, oOp_Count
  );

  modport slave (
    output iCmd_Valid, iCmd_A, iCmd_B, iDone, iProduct, iResult_Ready,
    input  oCmd_Ready, oData_A, oData_B, oValid_Data, oAck,
           oResult_Valid, oResult, oError, oOp_Count
  );
endinterface

// File: rtl/mult_request_driver.sv
// Requester/consumer end of the shift-add multiplier handshake.
// Takes an operand pair from the host, presents it to the multiplier with a one-cycle
// start strobe, waits for done (or a watchdog timeout), captures the product, returns
// a one-cycle ack and then holds the result for the host until it is taken.
//   Clock  : single rising-edge clock
//   Reset  : synchronous, active-high; aborts any operation in flight
//   bus    : mult_request_driver_if master modport (command, multiplier and result ports)
// TIMEOUT must exceed WIDTH+4 so that a healthy multiplier always finishes first.
module mult_request_driver #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 80
) (
  input  logic                   Clock,
  input  logic                   Reset,
  mult_request_driver_if.master  bus
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     data_a_q, data_a_d;
  logic [WIDTH-1:0]     data_b_q, data_b_d;
  logic                 valid_data_q, valid_data_d;
  logic                 ack_q, ack_d;
  logic                 result_valid_q, result_valid_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 error_q, error_d;
  logic [15:0]          op_count_q, op_count_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  // Next-state and next-output logic. Every output is a flop, so each decision is taken
  // one cycle ahead: the strobe is set on the accept edge, the ack on the done edge and
  // the result-valid flag on the edge leaving ACK. Strobe and ack default low so they
  // can never last more than one cycle.
  always_comb begin
    state_d        = state_q;
    data_a_d       = data_a_q;
    data_b_d       = data_b_q;
    valid_data_d   = 1'b0;
    ack_d          = 1'b0;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    error_d        = error_q;
    op_count_d     = op_count_q;
    timer_d        = timer_q;

    case (state_q)
      S_IDLE: begin
        if (bus.iCmd_Valid) begin
          data_a_d     = bus.iCmd_A;
          data_b_d     = bus.iCmd_B;
          valid_data_d = 1'b1;
          state_d      = S_REQUEST;
        end
      end

      S_REQUEST: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      // Done is tested before the watchdog so a done arriving on the last allowed
      // cycle still counts as a good result. A timeout still sends the ack so the
      // multiplier's control machine is returned to its idle state.
      S_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (bus.iDone) begin
          result_d = bus.iProduct;
          error_d  = 1'b0;
          ack_d    = 1'b1;
          state_d  = S_ACK;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          result_d = '0;
          error_d  = 1'b1;
          ack_d    = 1'b1;
          state_d  = S_ACK;
        end
      end

      S_ACK: begin
        op_count_d     = op_count_q + 16'd1;
        result_valid_d = 1'b1;
        state_d        = S_HOLD;
      end

      S_HOLD: begin
        if (bus.iResult_Ready) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset returns everything to zero and IDLE, which also
  // silently abandons an operation in flight (no ack, no result).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      data_a_q       <= '0;
      data_b_q       <= '0;
      valid_data_q   <= 1'b0;
      ack_q          <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      error_q        <= 1'b0;
      op_count_q     <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      data_a_q       <= data_a_d;
      data_b_q       <= data_b_d;
      valid_data_q   <= valid_data_d;
      ack_q          <= ack_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      error_q        <= error_d;
      op_count_q     <= op_count_d;
      timer_q        <= timer_d;
    end
  end

  // Ready is gated by Reset so the host sees no ready while reset is held.
  assign bus.oCmd_Ready    = (state_q == S_IDLE) && !Reset;
  assign bus.oData_A       = data_a_q;
  assign bus.oData_B       = data_b_q;
  assign bus.oValid_Data   = valid_data_q;
  assign bus.oAck          = ack_q;
  assign bus.oResult_Valid = result_valid_q;
  assign bus.oResult       = result_q;
  assign bus.oError        = error_q;
  assign bus.oOp_Count     = op_count_q;

endmodule

// File: tb/tb_mult_request_driver.sv
// Testbench for mult_request_driver. It plays both host and multiplier, keeps a
// timestamp-based reference model of the handshake and compares every output on every
// cycle, and adds literal expectations for the documented scenarios.
module tb_mult_request_driver;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 80;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  mult_request_driver_if #(.WIDTH(WIDTH)) bus ();

  mult_request_driver #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  // Cycle index, advanced on each rising edge by the model process.
  int cyc = 0;

  // Multiplier emulation controls, set by the host tasks before each operation.
  int          doneDelayG = -1;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;

  // Pulse totals seen on the outputs, used to show an aborted operation never acks.
  int ackTotal = 0;
  int rvTotal  = 0;

  // Reference model: one operation is described by its accept cycle and its done cycle;
  // every output is a function of the current cycle relative to those timestamps.
  bit          mActive  = 1'b0;
  bit          mBusy    = 1'b0;
  bit          mHasDone = 1'b0;
  int          tAccept  = 0;
  int          tDone    = 0;
  logic [31:0] mDataA   = '0;
  logic [31:0] mDataB   = '0;
  logic [63:0] mResult  = '0;
  bit          mError   = 1'b0;
  logic [15:0] mCount   = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Model update at each rising edge using the inputs the DUT samples on that edge.
  initial begin
    forever begin
      @(posedge Clock);
      if (Reset) begin
        mActive  = 1'b1;
        mBusy    = 1'b0;
        mHasDone = 1'b0;
        mDataA   = '0;
        mDataB   = '0;
        mResult  = '0;
        mError   = 1'b0;
        mCount   = '0;
      end else if (!mBusy) begin
        if (bus.iCmd_Valid) begin
          mBusy    = 1'b1;
          mHasDone = 1'b0;
          tAccept  = cyc;
          mDataA   = bus.iCmd_A;
          mDataB   = bus.iCmd_B;
        end
      end else if (!mHasDone) begin
        if (cyc >= tAccept + 2) begin
          if (bus.iDone) begin
            mHasDone = 1'b1;
            tDone    = cyc;
            mResult  = bus.iProduct;
            mError   = 1'b0;
          end else if (cyc - (tAccept + 2) == TIMEOUT - 1) begin
            mHasDone = 1'b1;
            tDone    = cyc;
            mResult  = '0;
            mError   = 1'b1;
          end
        end
      end else begin
        if (cyc == tDone + 1) mCount = mCount + 16'd1;
        else if (cyc >= tDone + 2 && bus.iResult_Ready) mBusy = 1'b0;
      end
      cyc++;
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge Clock);
      if (mActive) begin
        checkOutput("cmd_ready", bus.oCmd_Ready, !mBusy && !Reset);
        checkOutput("valid_data", bus.oValid_Data, mBusy && cyc == tAccept + 1);
        checkOutput("ack", bus.oAck, mBusy && mHasDone && cyc == tDone + 1);
        checkOutput("result_valid", bus.oResult_Valid, mBusy && mHasDone && cyc >= tDone + 2);
        checkOutput("result", bus.oResult, mResult);
        checkOutput("error", bus.oError, mError);
        checkOutput("op_count", bus.oOp_Count, mCount);
        checkOutput("data_a", bus.oData_A, mDataA);
        checkOutput("data_b", bus.oData_B, mDataB);
      end
    end
  end

  // Pulse counters.
  initial begin
    forever begin
      @(negedge Clock);
      if (bus.oAck) ackTotal++;
      if (bus.oResult_Valid) rvTotal++;
    end
  end

  // Multiplier emulation: on seeing the strobe, count doneDelayG WAIT cycles and then
  // raise done for one cycle with the true product. A stray done is sometimes raised in
  // the strobe cycle itself, and the product bus carries junk whenever done is low.
  initial begin
    int countdown;
    countdown    = -1;
    bus.iDone    = 1'b0;
    bus.iProduct = '0;
    forever begin
      @(posedge Clock);
      #1;
      if (bus.oValid_Data) begin
        countdown    = doneDelayG;
        bus.iDone    = 1'($urandom_range(0, 1));
        bus.iProduct = {$urandom, $urandom};
      end else if (countdown == 0) begin
        bus.iDone    = 1'b1;
        bus.iProduct = 64'(opA) * 64'(opB);
        countdown    = -1;
      end else begin
        if (countdown > 0) countdown--;
        bus.iDone    = 1'b0;
        bus.iProduct = {$urandom, $urandom};
      end
    end
  end

  // Holds iCmd_Valid until the driver is seen ready on a rising edge.
  task automatic waitAccept();
    bit accepted;
    int guard;
    accepted = 1'b0;
    guard    = 0;
    while (!accepted && guard < 200) begin
      @(negedge Clock);
      accepted = bus.oCmd_Ready;
      @(posedge Clock);
      #1;
      guard++;
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  // Runs one operation end to end and reports what was observed.
  // doneDelay: WAIT cycles before done (-1 = never); holdCycles: HOLD cycles with ready
  // low (0 = ready already high); busyValid: keep offering another pair while busy.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int doneDelay, input int holdCycles, input bit busyValid,
                               output int strobes, output int acks, output int lat,
                               output int rvCycles, output logic [63:0] res, output logic err);
    bit sawRv;
    bit finished;
    int cnt;
    int strobeCyc;
    opA               = a;
    opB               = b;
    doneDelayG        = doneDelay;
    bus.iCmd_A        = a;
    bus.iCmd_B        = b;
    bus.iCmd_Valid    = 1'b1;
    bus.iResult_Ready = (holdCycles == 0);
    waitAccept();
    if (busyValid) begin
      bus.iCmd_A = ~a;
      bus.iCmd_B = ~b;
    end else begin
      bus.iCmd_Valid = 1'b0;
    end
    sawRv = 0; finished = 0; cnt = 0; strobeCyc = 0;
    strobes = 0; acks = 0; lat = -1; rvCycles = 0; res = '0; err = 1'b0;
    while (!finished && cnt < TIMEOUT + 60) begin
      @(negedge Clock);
      if (bus.oValid_Data) begin
        strobes++;
        strobeCyc = cyc;
      end
      if (bus.oAck) acks++;
      if (bus.oResult_Valid) begin
        if (!sawRv) begin
          sawRv = 1'b1;
          lat   = cyc - strobeCyc;
          res   = bus.oResult;
          err   = bus.oError;
        end
        rvCycles++;
      end else if (sawRv) begin
        finished = 1'b1;
      end
      cnt++;
      @(posedge Clock);
      #1;
      if (finished) begin
        bus.iResult_Ready = 1'b0;
      end else if (sawRv && rvCycles >= holdCycles) begin
        bus.iResult_Ready = 1'b1;
        bus.iCmd_Valid    = 1'b0;
      end
    end
    bus.iCmd_Valid    = 1'b0;
    bus.iResult_Ready = 1'b0;
    if (!finished) checkOutput("op_completion_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int          strobes, acks, lat, rvCycles;
    logic [63:0] res;
    logic        err;
    int          ackBefore, rvBefore;

    Reset             = 1'b1;
    bus.iCmd_Valid    = 1'b0;
    bus.iCmd_A        = '0;
    bus.iCmd_B        = '0;
    bus.iResult_Ready = 1'b0;

    // Reset held for three cycles, then released.
    @(posedge Clock);
    #1;
    @(negedge Clock);
    checkOutput("rst_cmd_ready", bus.oCmd_Ready, 0);
    checkOutput("rst_result", bus.oResult, 0);
    checkOutput("rst_op_count", bus.oOp_Count, 0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("rel_cmd_ready", bus.oCmd_Ready, 1);
    checkOutput("rel_op_count", bus.oOp_Count, 0);
    @(posedge Clock);
    #1;

    // 10 x 16 with done 34 cycles after the strobe.
    applyStimulus(32'd10, 32'd16, 33, 2, 1'b0, strobes, acks, lat, rvCycles, res, err);
    checkOutput("t2_result", res, 64'd160);
    checkOutput("t2_error", err, 0);
    checkOutput("t2_strobes", strobes, 1);
    checkOutput("t2_acks", acks, 1);
    checkOutput("t2_latency", lat, 36);
    checkOutput("t2_op_count", bus.oOp_Count, 1);

    // Full-width operands: whole 64-bit product must be captured.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 1, 1'b0, strobes, acks, lat, rvCycles, res, err);
    checkOutput("t3_result", res, 64'hFFFF_FFFE_0000_0001);
    checkOutput("t3_error", err, 0);

    // Done never arrives: watchdog abort after 80 WAIT cycles, ack still sent.
    applyStimulus(32'd3, 32'd4, -1, 1, 1'b0, strobes, acks, lat, rvCycles, res, err);
    checkOutput("t4_result", res, 0);
    checkOutput("t4_error", err, 1);
    checkOutput("t4_acks", acks, 1);
    checkOutput("t4_latency", lat, 82);

    // Done on the last allowed WAIT cycle wins over the timeout.
    applyStimulus(32'd1000, 32'd3, TIMEOUT - 1, 1, 1'b0, strobes, acks, lat, rvCycles, res, err);
    checkOutput("tlast_result", res, 64'd3000);
    checkOutput("tlast_error", err, 0);
    checkOutput("tlast_latency", lat, 82);

    // Result held 10 cycles with a competing command offered throughout.
    applyStimulus(32'd5, 32'd7, 3, 10, 1'b1, strobes, acks, lat, rvCycles, res, err);
    checkOutput("t5_result", res, 64'd35);
    checkOutput("t5_rv_cycles", rvCycles, 11);
    checkOutput("t5_strobes", strobes, 1);
    checkOutput("t5_data_a_held", bus.oData_A, 32'd5);
    checkOutput("t5_op_count", bus.oOp_Count, 5);

    // Fastest path: done in the first WAIT cycle, ready already high.
    applyStimulus(32'd9, 32'd9, 0, 0, 1'b0, strobes, acks, lat, rvCycles, res, err);
    checkOutput("tmin_result", res, 64'd81);
    checkOutput("tmin_latency", lat, 3);
    checkOutput("tmin_rv_cycles", rvCycles, 1);

    // Randomized operations with arithmetic expectations per operation.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      int          sel, dly, hold;
      bit          bv, timedOut;
      a    = $urandom;
      b    = $urandom;
      sel  = $urandom_range(0, 9);
      dly  = (sel == 0) ? -1 : (sel == 1) ? TIMEOUT - 1 : (sel == 2) ? TIMEOUT + 3
                                                         : $urandom_range(0, 40);
      hold = $urandom_range(0, 4);
      bv   = 1'($urandom_range(0, 1));
      timedOut = (dly < 0) || (dly > TIMEOUT - 1);
      applyStimulus(a, b, dly, hold, bv, strobes, acks, lat, rvCycles, res, err);
      checkOutput("rnd_result", res, timedOut ? 64'd0 : 64'(a) * 64'(b));
      checkOutput("rnd_error", err, timedOut);
      checkOutput("rnd_latency", lat, timedOut ? TIMEOUT + 2 : dly + 3);
      checkOutput("rnd_rv_cycles", rvCycles, hold + 1);
      checkOutput("rnd_acks", acks, 1);
    end

    // Reset in the middle of WAIT: no ack, no result, idle straight after.
    doneDelayG     = -1;
    bus.iCmd_A     = 32'd11;
    bus.iCmd_B     = 32'd12;
    bus.iCmd_Valid = 1'b1;
    waitAccept();
    bus.iCmd_Valid = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    ackBefore = ackTotal;
    rvBefore  = rvTotal;
    Reset     = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("mid_rst_ready", bus.oCmd_Ready, 1);
    checkOutput("mid_rst_op_count", bus.oOp_Count, 0);
    repeat (TIMEOUT + 10) @(posedge Clock);
    #1;
    checkOutput("mid_rst_acks", ackTotal - ackBefore, 0);
    checkOutput("mid_rst_rv", rvTotal - rvBefore, 0);

    // Operation counter wrap from 0xFFFF to 0.
    force dut.op_count_q = 16'hFFFF;
    mCount = 16'hFFFF;
    @(posedge Clock);
    #1;
    release dut.op_count_q;
    applyStimulus(32'd2, 32'd2, 5, 0, 1'b0, strobes, acks, lat, rvCycles, res, err);
    checkOutput("wrap_op_count", bus.oOp_Count, 0);
    applyStimulus(32'd6, 32'd7, 6, 1, 1'b0, strobes, acks, lat, rvCycles, res, err);
    checkOutput("post_wrap_op_count", bus.oOp_Count, 1);
    checkOutput("post_wrap_result", res, 64'd42);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
